// File: rtl/fpm_pipe.sv
// Pipelined IEEE-754 multiplier with generic widths, five rounding modes, per-result and sticky flags.
// Latency: operand accepted at edge k gives out_valid after edge k+3; one result per cycle.
// Backpressure: one global enable stalls every stage while out_valid && !out_ready. FPM_SUBNORMAL_EN enables gradual underflow.
module fpm_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             r_mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   fp_X,
    input  logic [EXP_W+MAN_W:0]   fp_Y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   fp_Z,
    output logic                   ovrf,
    output logic                   udrf,
    output logic                   nv,
    output logic                   nx,
    input  logic                   clr_flags,
    output logic [3:0]             sticky_flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + $clog2(PW) + 2;
    localparam logic signed [EW-1:0] ONE    = EW'(1);
    localparam logic signed [EW-1:0] BIAS_S = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef struct packed {
        logic nan;
        logic nv;
        logic inf;
        logic zero;
    } spc_t;

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    logic           v0, v1, v2;
    logic [W-1:0]   x0, y0;
    logic [2:0]     rm0, rm1, rm2;
    logic           sgn1, sgn2;
    logic signed [EW-1:0] e1, e2;
    logic [PW-1:0]  prod1;
    spc_t           spc1, spc2;
    logic [MAN_W-1:0] frac2;
    logic           g2, st2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0  <= 1'b0;
            x0  <= '0;
            y0  <= '0;
            rm0 <= '0;
        end else if (en) begin
            v0 <= in_valid;
            if (in_valid) begin
                x0  <= fp_X;
                y0  <= fp_Y;
                rm0 <= r_mode;
            end
        end
    end

    // S1: unpack / classify / exponent add / significand multiply
    logic [EXP_W-1:0] ex, ey;
    logic [MAN_W-1:0] mx, my;
    logic x_zero, y_zero, x_inf, y_inf, x_nan, y_nan, inf_zero;
    logic [EW-1:0] ex_eff, ey_eff;
    spc_t spc_s1;

    assign ex = x0[W-2 -: EXP_W];
    assign ey = y0[W-2 -: EXP_W];
    assign mx = x0[MAN_W-1:0];
    assign my = y0[MAN_W-1:0];
`ifdef FPM_SUBNORMAL_EN
    assign x_zero = (ex == '0) && (mx == '0);
    assign y_zero = (ey == '0) && (my == '0);
`else
    assign x_zero = (ex == '0);
    assign y_zero = (ey == '0);
`endif
    assign x_inf    = (&ex) && (mx == '0);
    assign y_inf    = (&ey) && (my == '0);
    assign x_nan    = (&ex) && (mx != '0);
    assign y_nan    = (&ey) && (my != '0);
    assign inf_zero = (x_inf && y_zero) || (y_inf && x_zero);
    assign ex_eff   = (ex == '0) ? EW'(1) : EW'(ex);
    assign ey_eff   = (ey == '0) ? EW'(1) : EW'(ey);

    always_comb begin
        spc_s1.nan  = x_nan || y_nan || inf_zero;
        spc_s1.nv   = (x_nan && !mx[MAN_W-1]) || (y_nan && !my[MAN_W-1]) || inf_zero;
        spc_s1.inf  = (x_inf || y_inf) && !spc_s1.nan;
        spc_s1.zero = (x_zero || y_zero) && !spc_s1.nan;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            sgn1  <= 1'b0;
            e1    <= '0;
            prod1 <= '0;
            spc1  <= '0;
            rm1   <= '0;
        end else if (en) begin
            v1    <= v0;
            sgn1  <= x0[W-1] ^ y0[W-1];
            e1    <= ex_eff + ey_eff - BIAS_S;
            prod1 <= PW'({ex != '0, mx}) * PW'({ey != '0, my});
            spc1  <= spc_s1;
            rm1   <= rm0;
        end
    end

    // S2: normalise so the leading one sits at prod bit PW-1, then split into fraction/guard/sticky
    logic signed [EW-1:0] s2_e;
    logic [MAN_W-1:0]     s2_frac;
    logic                 s2_g, s2_st;
`ifdef FPM_SUBNORMAL_EN
    localparam int LZW = $clog2(PW) + 1;
    function automatic logic [LZW-1:0] lzc(input logic [PW-1:0] v);
        logic [LZW-1:0] n;
        n = LZW'(PW);
        for (int i = 0; i < PW; i++)
            if (v[i]) n = LZW'(PW - 1 - i);
        return n;
    endfunction

    logic [LZW-1:0]       lz;
    logic [PW-1:0]        norm, shifted;
    logic signed [EW-1:0] e_n;
    logic [EW-1:0]        sh;
    logic                 lost;

    always_comb begin
        lz      = lzc(prod1);
        norm    = prod1 << lz;
        e_n     = e1 + ONE - EW'(lz);
        sh      = '0;
        if (e_n < ONE) sh = ONE - e_n;
        shifted = norm >> sh;
        lost    = |(norm & ~({PW{1'b1}} << sh));
        // a cleared implicit bit after the shift means a denormal: exponent field 0
        s2_e    = shifted[PW-1] ? e_n : '0;
        s2_frac = shifted[PW-2 -: MAN_W];
        s2_g    = shifted[MAN_W];
        s2_st   = (|shifted[MAN_W-1:0]) | lost;
    end
`else
    always_comb begin
        if (prod1[PW-1]) begin
            s2_e    = e1 + ONE;
            s2_frac = prod1[PW-2 -: MAN_W];
            s2_g    = prod1[MAN_W];
            s2_st   = |prod1[MAN_W-1:0];
        end else begin
            s2_e    = e1;
            s2_frac = prod1[PW-3 -: MAN_W];
            s2_g    = prod1[MAN_W-1];
            s2_st   = |prod1[MAN_W-2:0];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2    <= 1'b0;
            sgn2  <= 1'b0;
            e2    <= '0;
            frac2 <= '0;
            g2    <= 1'b0;
            st2   <= 1'b0;
            spc2  <= '0;
            rm2   <= '0;
        end else if (en) begin
            v2    <= v1;
            sgn2  <= sgn1;
            e2    <= s2_e;
            frac2 <= s2_frac;
            g2    <= s2_g;
            st2   <= s2_st;
            spc2  <= spc1;
            rm2   <= rm1;
        end
    end

    // S3: round; the increment carries from the fraction straight into the exponent field
    logic                 inexact, inc, to_inf;
    logic [EW+MAN_W-1:0]  rsum;
    logic signed [EW-1:0] re;
    logic [W-1:0]         res;
    logic [3:0]           fl;

    always_comb begin
        inexact = g2 | st2;
        case (rm2)
            3'b000:  inc = 1'b0;
            3'b001:  inc = sgn2 & inexact;
            3'b010:  inc = ~sgn2 & inexact;
            3'b011:  inc = g2;
            default: inc = g2 & (st2 | frac2[0]);
        endcase
        to_inf = !((rm2 == 3'b000) || (rm2 == 3'b001 && !sgn2) || (rm2 == 3'b010 && sgn2));
        rsum   = {e2, frac2} + {{(EW+MAN_W-1){1'b0}}, inc};
        re     = rsum[EW+MAN_W-1 -: EW];
        res    = {sgn2, re[EXP_W-1:0], rsum[MAN_W-1:0]};
        fl     = {3'b000, inexact};
        if (spc2.nan) begin
            res = QNAN;
            fl  = {spc2.nv, 3'b000};
        end else if (spc2.inf) begin
            res = {sgn2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            fl  = 4'b0000;
        end else if (spc2.zero) begin
            res = {sgn2, {(W-1){1'b0}}};
            fl  = 4'b0000;
        end else if (re >= EMAX_S) begin
            res = to_inf ? {sgn2, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                         : {sgn2, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            fl  = 4'b0101;
`ifdef FPM_SUBNORMAL_EN
        end else if (re == '0 && inexact) begin
            fl  = 4'b0011;
`else
        end else if (re < ONE) begin
            res = {sgn2, {(W-1){1'b0}}};
            fl  = 4'b0011;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            fp_Z      <= '0;
            {nv, ovrf, udrf, nx} <= 4'b0000;
        end else if (en) begin
            out_valid <= v2;
            if (v2) begin
                fp_Z <= res;
                {nv, ovrf, udrf, nx} <= fl;
            end
        end
    end

    logic hs;
    assign hs = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sticky_flags <= 4'b0000;
        else if (clr_flags)
            sticky_flags <= hs ? {nv, ovrf, udrf, nx} : 4'b0000;
        else if (hs)
            sticky_flags <= sticky_flags | {nv, ovrf, udrf, nx};
    end
endmodule

// File: tb/tb_fpm_pipe.sv
// Scoreboard bench for fpm_pipe (single precision): expected results queued at issue, compared at handshake.
module tb_fpm_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  r_mode = 3'b100;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] fp_X = '0;
    logic [31:0] fp_Y = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] fp_Z;
    logic        ovrf, udrf, nv, nx;
    logic        clr_flags = 1'b0;
    logic [3:0]  sticky_flags;
    logic [3:0]  flags;

    typedef struct packed {
        logic [31:0] z;
        logic [3:0]  f;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    logic [3:0] sticky_model = 4'b0000;

    assign flags = {nv, ovrf, udrf, nx};

    always #5 clk = ~clk;

    fpm_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .r_mode(r_mode),
        .in_valid(in_valid), .in_ready(in_ready),
        .fp_X(fp_X), .fp_Y(fp_Y),
        .out_valid(out_valid), .out_ready(out_ready),
        .fp_Z(fp_Z), .ovrf(ovrf), .udrf(udrf), .nv(nv), .nx(nx),
        .clr_flags(clr_flags), .sticky_flags(sticky_flags)
    );

    // Drive one operand pair from a negedge until accepted; returns on the following negedge.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm,
                         input logic [31:0] ez, input logic [3:0] ef);
        int b;
        fp_X = x;
        fp_Y = y;
        r_mode = rm;
        in_valid = 1'b1;
        sb.push_back({ez, ef});
        b = 0;
        while (!in_ready && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: in_ready=%b, required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, fp_Z, flags, sticky_flags} !== '0) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b fp_Z=%h flags=%b sticky=%b, required all 0",
                     out_valid, fp_Z, flags, sticky_flags);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_latency();
        exp_t e;
        int lat;
        out_ready = 1'b1;
        issue(32'h3FC00000, 32'h40000000, 3'b100, 32'h40400000, 4'b0000);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL latency: got %0d cycles, required 3", lat);
        end
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        checks++;
        if (!out_valid || {fp_Z, flags} !== e) begin
            failures++;
            $display("FAIL latency_result: valid=%b z=%h f=%b, required z=%h f=%b",
                     out_valid, fp_Z, flags, e.z, e.f);
        end
        sticky_model |= e.f;
        @(negedge clk);
    endtask

    task automatic test_rounding();
        exp_t e;
        int got;
        out_ready = 1'b1;
        got = 0;
        fork
            begin
                issue(32'h03C00000, 32'h5F800001, 3'b100, 32'h23C00002, 4'b0001);
                issue(32'h03C00000, 32'h5F800001, 3'b000, 32'h23C00001, 4'b0001);
                issue(32'h03C00000, 32'h5F800001, 3'b010, 32'h23C00002, 4'b0001);
                issue(32'h03C00000, 32'h5F800001, 3'b001, 32'h23C00001, 4'b0001);
                issue(32'h03C00000, 32'h5F800001, 3'b011, 32'h23C00002, 4'b0001);
                issue(32'h83C00000, 32'h5F800001, 3'b001, 32'hA3C00002, 4'b0001);
                issue(32'h83C00000, 32'h5F800001, 3'b010, 32'hA3C00001, 4'b0001);
            end
            begin
                for (int c = 0; c < 60 && got < 7; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        e = (sb.size() > 0) ? sb.pop_front() : 'x;
                        checks++;
                        if ({fp_Z, flags} !== e) begin
                            failures++;
                            $display("FAIL rounding[%0d]: z=%h f=%b, required z=%h f=%b",
                                     got, fp_Z, flags, e.z, e.f);
                        end
                        sticky_model |= e.f;
                        got++;
                    end
                end
            end
        join
        if (got < 7) begin
            checks++;
            failures++;
            $display("FAIL rounding_timeout: got %0d results, required 7", got);
        end
        @(negedge clk);
    endtask

    task automatic test_overflow_underflow();
        exp_t e;
        int got;
        out_ready = 1'b1;
        got = 0;
        fork
            begin
                issue(32'h7F000000, 32'h40000000, 3'b100, 32'h7F800000, 4'b0101);
                issue(32'h7F000000, 32'h40000000, 3'b000, 32'h7F7FFFFF, 4'b0101);
                issue(32'h7F000000, 32'h40000000, 3'b001, 32'h7F7FFFFF, 4'b0101);
                issue(32'h7F000000, 32'h40000000, 3'b010, 32'h7F800000, 4'b0101);
                issue(32'hFF000000, 32'h40000000, 3'b010, 32'hFF7FFFFF, 4'b0101);
                issue(32'hFF000000, 32'h40000000, 3'b001, 32'hFF800000, 4'b0101);
                issue(32'h0A0A0A0A, 32'h0A0A0A0A, 3'b100, 32'h00000000, 4'b0011);
            end
            begin
                for (int c = 0; c < 60 && got < 7; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        e = (sb.size() > 0) ? sb.pop_front() : 'x;
                        checks++;
                        if ({fp_Z, flags} !== e) begin
                            failures++;
                            $display("FAIL ovf_udf[%0d]: z=%h f=%b, required z=%h f=%b",
                                     got, fp_Z, flags, e.z, e.f);
                        end
                        sticky_model |= e.f;
                        got++;
                    end
                end
            end
        join
        if (got < 7) begin
            checks++;
            failures++;
            $display("FAIL ovf_udf_timeout: got %0d results, required 7", got);
        end
        @(negedge clk);
    endtask

    task automatic test_specials();
        exp_t e;
        int got;
        logic [31:0] sub_z1, sub_z2;
        logic [3:0]  sub_f1;
`ifdef FPM_SUBNORMAL_EN
        sub_z1 = 32'h00400000; sub_f1 = 4'b0000; sub_z2 = 32'h00000001;
`else
        sub_z1 = 32'h00000000; sub_f1 = 4'b0011; sub_z2 = 32'h00000000;
`endif
        out_ready = 1'b1;
        got = 0;
        fork
            begin
                issue(32'h7F800000, 32'h00000000, 3'b100, 32'h7FC00000, 4'b1000);
                issue(32'hFF800000, 32'h40000000, 3'b100, 32'hFF800000, 4'b0000);
                issue(32'h7FA00000, 32'h3F800000, 3'b100, 32'h7FC00000, 4'b1000);
                issue(32'h7FC00001, 32'h3F800000, 3'b100, 32'h7FC00000, 4'b0000);
                issue(32'h80000000, 32'h3F800000, 3'b100, 32'h80000000, 4'b0000);
                issue(32'h00000000, 32'hFF800000, 3'b000, 32'h7FC00000, 4'b1000);
                issue(32'h00800000, 32'h3F000000, 3'b100, sub_z1, sub_f1);
                issue(32'h00000001, 32'h3F800000, 3'b100, sub_z2, 4'b0000);
            end
            begin
                for (int c = 0; c < 60 && got < 8; c++) begin
                    @(negedge clk);
                    if (out_valid && out_ready) begin
                        e = (sb.size() > 0) ? sb.pop_front() : 'x;
                        checks++;
                        if ({fp_Z, flags} !== e) begin
                            failures++;
                            $display("FAIL special_subnormal[%0d]: z=%h f=%b, required z=%h f=%b",
                                     got, fp_Z, flags, e.z, e.f);
                        end
                        sticky_model |= e.f;
                        got++;
                    end
                end
            end
        join
        if (got < 8) begin
            checks++;
            failures++;
            $display("FAIL special_timeout: got %0d results, required 8", got);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int got;
        logic [31:0] z_hold;
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        sticky_model = 4'b0000;
        checks++;
        if (sticky_flags !== 4'b0000) begin
            failures++;
            $display("FAIL sticky_clear: got %b, required 0000", sticky_flags);
        end
        out_ready = 1'b0;
        issue(32'h3FC00000, 32'h40000000, 3'b100, 32'h40400000, 4'b0000);
        issue(32'h7F000000, 32'h40000000, 3'b100, 32'h7F800000, 4'b0101);
        issue(32'h7F800000, 32'h00000000, 3'b100, 32'h7FC00000, 4'b1000);
        issue(32'h03C00000, 32'h5F800001, 3'b100, 32'h23C00002, 4'b0001);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_full: in_ready=%b out_valid=%b, required 0 and 1", in_ready, out_valid);
        end
        z_hold = fp_Z;
        repeat (3) @(negedge clk);
        checks++;
        if (fp_Z !== z_hold || fp_Z !== sb[0].z) begin
            failures++;
            $display("FAIL stall_hold: fp_Z=%h, required %h", fp_Z, sb[0].z);
        end
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            if (out_valid && out_ready) begin
                e = (sb.size() > 0) ? sb.pop_front() : 'x;
                checks++;
                if ({fp_Z, flags} !== e) begin
                    failures++;
                    $display("FAIL b2b[%0d]: z=%h f=%b, required z=%h f=%b",
                             got, fp_Z, flags, e.z, e.f);
                end
                sticky_model |= e.f;
                got++;
            end
            @(negedge clk);
        end
        if (got < 4) begin
            checks++;
            failures++;
            $display("FAIL b2b_timeout: got %0d results, required 4", got);
        end
        checks++;
        if (sticky_flags !== sticky_model) begin
            failures++;
            $display("FAIL sticky_or: got %b, required %b", sticky_flags, sticky_model);
        end
    endtask

    task automatic test_reset_midstream();
        logic stale;
        out_ready = 1'b1;
        issue(32'h3FC00000, 32'h40000000, 3'b100, 32'h40400000, 4'b0000);
        issue(32'h7F000000, 32'h40000000, 3'b100, 32'h7F800000, 4'b0101);
        issue(32'h03C00000, 32'h5F800001, 3'b100, 32'h23C00002, 4'b0001);
        issue(32'h7F800000, 32'h00000000, 3'b100, 32'h7FC00000, 4'b1000);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, fp_Z, flags, sticky_flags} !== '0) begin
            failures++;
            $display("FAIL reset_midstream: out_valid=%b fp_Z=%h flags=%b sticky=%b, required all 0",
                     out_valid, fp_Z, flags, sticky_flags);
        end
        sb.delete();
        sticky_model = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        checks++;
        if (stale !== 1'b0) begin
            failures++;
            $display("FAIL reset_stale: out_valid seen=%b, required 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_overflow_underflow();
        test_specials();
        test_back_to_back();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fpm_pipe.md
Name: fpm_pipe

Overview:
Parametrised, fully pipelined IEEE-754 binary floating-point multiplier.
- Successor to the fixed single-precision multiplier. Adds generic exponent/mantissa widths, valid/ready flow control, a 3-stage pipeline, five rounding modes and IEEE exception flags (per result and sticky).
- Sits between an operand-issue stage and a result consumer in the arithmetic datapath.

Parameters:
EXP_W, 8, exponent field width (>=4)
MAN_W, 23, stored fraction width (>=4); word width W = 1+EXP_W+MAN_W

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
r_mode  in  3  rounding mode, sampled with operands: 000 RTZ, 001 RDN(-inf), 010 RUP(+inf), 011 RNA(ties away), 100 RNE; others treated as RNE
in_valid  in  1  operand pair valid
in_ready  out  1  pipeline can accept
fp_X  in  W  operand X
fp_Y  in  W  operand Y
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
fp_Z  out  W  product
ovrf  out  1  overflow, qualified by out_valid
udrf  out  1  underflow, qualified by out_valid
nv  out  1  invalid operation, qualified by out_valid
nx  out  1  inexact, qualified by out_valid
clr_flags  in  1  synchronous clear of sticky flags
sticky_flags  out  4  accumulated {nv,ovrf,udrf,nx} of all handed-off results

Behaviour:
- Reset (async, rst_n=0):
  - all stage valids, out_valid, fp_Z, ovrf, udrf, nv, nx and sticky_flags go to 0.
  - In-flight operations are discarded; nothing is emitted after release.
- Pipeline advance:
  - Global enable en = !out_valid || out_ready; in_ready = en (combinational).
  - Accept on in_valid && in_ready. Bubbles advance as invalid slots.
- Latency: an operand pair accepted at edge k presents out_valid=1 after edge k+3 when there is no stall. Throughput is 1/cycle.
- While out_valid && !out_ready: fp_Z and all flags hold stable, and no stage changes.
- Stages:
  - S1: unpack, classify (zero/inf/NaN/subnormal/normal), XOR signs, add biased exponents, multiply full (MAN_W+1)x(MAN_W+1) significands.
  - S2: normalise (1-bit shift, plus leading-zero shift for subnormal inputs when the optional feature is enabled); form guard and sticky bits; apply a right shift for tiny results.
  - S3: round per r_mode; handle carry-out renormalisation; detect overflow/underflow; select special results; register outputs.
- Special cases:
  - Any NaN input, or inf x 0 → canonical qNaN {0, all-ones exp, 1, zeros}. nv=1 only for inf x 0 or a signalling-NaN input.
  - inf x finite nonzero → signed inf.
  - 0 x finite → signed zero.
  - Special results carry no ovrf/udrf/nx.
- Overflow (rounded exponent > max finite):
  - ovrf=1, nx=1.
  - Result: RNE/RNA → signed inf. RTZ → signed max finite. RDN → +max finite / -inf. RUP → +inf / -max finite.
- Underflow: udrf=1 when the result is tiny after rounding and inexact; nx is set on any discarded nonzero bits.
- Sticky flags:
  - sticky_flags |= {nv,ovrf,udrf,nx} on each handshake (out_valid && out_ready).
  - clr_flags clears them. If clear and a handshake occur in the same cycle, clear wins, then that result's flags are ORed in.

Optional Feature:
FPM_SUBNORMAL_EN.
- Defined: full gradual underflow. Subnormal inputs are normalised; tiny results are denormalised and rounded per r_mode.
- Undefined: flush-to-zero.
  - Subnormal inputs are treated as signed zero, with no flag.
  - Any finite nonzero result below min normal becomes signed zero with udrf=1, nx=1.
  - Saves the leading-zero shifter.

Test Plan:
1. RNE, 0x3FC00000 x 0x40000000, in_valid 1 cycle, out_ready=1 → out_valid exactly 3 cycles later, fp_Z=0x40400000, flags 0.
2. Tie rounding: 0x03C00000 x 0x5F800001 → RNE 0x23C00002, RTZ 0x23C00001, RUP 0x23C00002, nx=1 in each mode.
3. 0x7F000000 x 0x40000000 → RNE 0x7F800000, RTZ 0x7F7FFFFF, RDN 0x7F7FFFFF, ovrf=1 nx=1. 0x0A0A0A0A x 0x0A0A0A0A → 0x00000000, udrf=1 nx=1.
4. Specials: 0x7F800000 x 0x00000000 → 0x7FC00000 nv=1. 0xFF800000 x 0x40000000 → 0xFF800000, no flags. 0x7FA00000 x 0x3F800000 → 0x7FC00000 nv=1.
5. Subnormals: 0x00800000 x 0x3F000000 → with FPM_SUBNORMAL_EN 0x00400000 flags 0; without it 0x00000000 udrf=1 nx=1.
6. Backpressure and reset:
   - Issue 4 back-to-back ops with out_ready=0 → in_ready drops after the pipe fills, fp_Z holds; release → 4 results in order, sticky_flags equals the OR of their flags.
   - Assert rst_n=0 mid-stream → outputs 0 immediately, no stale result after release.
